// File: rtl/conv_window_sched.sv
// Raster-stream scheduler for the 3x3 PE window. Each qualifying pixel starts a window: pe_rst at T+1, pe_en T+2..T+4, out_valid T+5.
// Backpressure: pix_ready is high only in LOAD, so the stream is held from the qualifying accept until OUT has finished.
module conv_window_sched #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int CW    = 4,
  parameter int RW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          stride,
  input  logic          pix_valid,
  output logic          pix_ready,
  output logic [3:0]    buf_wr_sel,
  output logic [1:0]    rd_top,
  output logic [CW-1:0] win_col,
  output logic [1:0]    win_col_sel,
  output logic          pe_rst,
  output logic          pe_en,
  output logic          out_valid,
  output logic          busy,
  output logic          done
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CLR, S_MAC, S_OUT, S_DONE} state_t;

  state_t        r_state;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [3:0]    r_buf_wr_sel;
  logic          r_stride;
  logic [CW-1:0] r_base;
  logic          r_last;
  logic          r_pix_ready;
  logic [1:0]    r_rd_top;
  logic [CW-1:0] r_win_col;
  logic [1:0]    r_win_col_sel;
  logic          r_pe_rst;
  logic          r_pe_en;
  logic          r_out_valid;
  logic          r_busy;
  logic          r_done;

  logic w_accept, w_col_end, w_row_end, w_last, w_qual;
  logic [1:0] w_top;
  logic [1:0] w_tap_nxt;

  assign w_accept  = r_pix_ready & pix_valid;
  assign w_col_end = (r_col == CW'(IMG_W - 1));
  assign w_row_end = (r_row == RW'(IMG_H - 1));
  assign w_last    = w_row_end & w_col_end;
  // Stride 2 keeps only even rows and even columns of the output grid.
  assign w_qual    = (r_row >= RW'(2)) && (r_col >= CW'(2)) &&
                     (!r_stride || (!r_row[0] && !r_col[0]));
  assign w_top     = r_row[1:0] - 2'd2;
  assign w_tap_nxt = r_win_col_sel + 2'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_col         <= '0;
      r_row         <= '0;
      r_buf_wr_sel  <= 4'b0001;
      r_stride      <= 1'b0;
      r_base        <= '0;
      r_last        <= 1'b0;
      r_pix_ready   <= 1'b0;
      r_rd_top      <= 2'd0;
      r_win_col     <= '0;
      r_win_col_sel <= 2'd0;
      r_pe_rst      <= 1'b0;
      r_pe_en       <= 1'b0;
      r_out_valid   <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_pe_rst    <= 1'b0;
      r_pe_en     <= 1'b0;
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_stride     <= stride;
            r_col        <= '0;
            r_row        <= '0;
            r_buf_wr_sel <= 4'b0001;
            r_pix_ready  <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            if (w_col_end) begin
              r_col        <= '0;
              r_row        <= r_row + RW'(1);
              r_buf_wr_sel <= {r_buf_wr_sel[2:0], r_buf_wr_sel[3]};
            end else begin
              r_col <= r_col + CW'(1);
            end
            if (w_qual) begin
              r_base      <= r_col - CW'(2);
              r_rd_top    <= w_top;
              r_last      <= w_last;
              r_pix_ready <= 1'b0;
              r_pe_rst    <= 1'b1;
              r_state     <= S_CLR;
            end else if (w_last) begin
              r_pix_ready <= 1'b0;
              r_done      <= 1'b1;
              r_state     <= S_DONE;
            end
          end
        end
        S_CLR: begin
          r_win_col_sel <= 2'd0;
          r_win_col     <= r_base;
          r_pe_en       <= 1'b1;
          r_state       <= S_MAC;
        end
        S_MAC: begin
          if (r_win_col_sel == 2'd2) begin
            r_win_col_sel <= 2'd0;
            r_win_col     <= '0;
            r_out_valid   <= 1'b1;
            r_state       <= S_OUT;
          end else begin
            r_win_col_sel <= w_tap_nxt;
            r_win_col     <= r_base + CW'(w_tap_nxt);
            r_pe_en       <= 1'b1;
          end
        end
        S_OUT: begin
          r_rd_top <= 2'd0;
          if (r_last) begin
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_pix_ready <= 1'b1;
            r_state     <= S_LOAD;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign pix_ready   = r_pix_ready;
  assign buf_wr_sel  = r_buf_wr_sel;
  assign rd_top      = r_rd_top;
  assign win_col     = r_win_col;
  assign win_col_sel = r_win_col_sel;
  assign pe_rst      = r_pe_rst;
  assign pe_en       = r_pe_en;
  assign out_valid   = r_out_valid;
  assign busy        = r_busy;
  assign done        = r_done;

endmodule

// File: tb/tb_conv_window_sched.sv
// Scoreboard bench for conv_window_sched: the window list per frame comes from a plain output-grid model,
// and a negedge monitor checks every PE sequence, buffer steering and frame completion against it.
module tb_conv_window_sched;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int CW = 4;
  localparam int RW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, stride = 1'b0, pix_valid = 1'b0;
  logic pix_ready, pe_rst, pe_en, out_valid, busy, done;
  logic [3:0] buf_wr_sel;
  logic [1:0] rd_top, win_col_sel;
  logic [CW-1:0] win_col;

  conv_window_sched #(.IMG_W(W), .IMG_H(H), .CW(CW), .RW(RW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stride(stride), .pix_valid(pix_valid),
    .pix_ready(pix_ready), .buf_wr_sel(buf_wr_sel), .rd_top(rd_top), .win_col(win_col),
    .win_col_sel(win_col_sel), .pe_rst(pe_rst), .pe_en(pe_en), .out_valid(out_valid),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {int r; int c;} win_t;
  win_t exp_q[$];

  int checks = 0, errors = 0;
  int wins = 0, done_cnt = 0;
  int acc_r = 0, acc_c = 0, cyc = 0, rst_cyc = 0, ntap = 0;
  int cap_col[3], cap_sel[3];
  bit pend_clr = 0, pend_done = 0, prev_busy = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Windows sit on the output grid starting at (2,2), spaced by the stride.
  task automatic push_model(input bit s);
    int step;
    step = s ? 2 : 1;
    for (int r = 2; r < H; r += step)
      for (int c = 2; c < W; c += step)
        exp_q.push_back('{r, c});
  endtask

  function automatic int model_count(input bit s);
    if (s) return ((W - 1) / 2) * ((H - 1) / 2);
    return (W - 2) * (H - 2);
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      pend_clr = 0; pend_done = 0; prev_busy = 0; ntap = 0;
    end else begin
      bit inwin;
      win_t w;
      if (busy && !prev_busy) begin acc_r = 0; acc_c = 0; wins = 0; end
      prev_busy = busy;
      chk("pe_rst_timing", pe_rst, pend_clr);
      chk("done_timing", done, pend_done);
      pend_clr = 0; pend_done = 0;
      chk("pe_exclusive", (int'(pe_rst) + int'(pe_en) + int'(out_valid)) > 1, 0);
      inwin = pe_rst | pe_en | out_valid;
      if (inwin) begin
        chk("pix_ready_in_window", pix_ready, 0);
        if (exp_q.size() > 0) chk("rd_top", rd_top, (exp_q[0].r - 2) % 4);
      end else begin
        chk("rd_top_idle", rd_top, 0);
      end
      if (pe_rst) begin rst_cyc = cyc; ntap = 0; end
      if (pe_en) begin
        chk("pe_en_latency", cyc - rst_cyc, ntap + 1);
        if (ntap < 3) begin cap_col[ntap] = int'(win_col); cap_sel[ntap] = int'(win_col_sel); end
        ntap++;
      end
      if (out_valid) begin
        chk("out_valid_latency", cyc - rst_cyc, 4);
        chk("tap_count", ntap, 3);
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 1, 0);
        end else begin
          w = exp_q.pop_front();
          for (int t = 0; t < 3; t++) begin
            chk("win_col", cap_col[t], w.c - 2 + t);
            chk("win_col_sel", cap_sel[t], t);
          end
          if (w.r == H - 1 && w.c == W - 1) pend_done = 1;
        end
        wins++;
      end
      if (done) done_cnt++;
      if (pix_valid && pix_ready) begin
        chk("buf_wr_sel", buf_wr_sel, 1 << (acc_r % 4));
        if (exp_q.size() > 0 && exp_q[0].r == acc_r && exp_q[0].c == acc_c) pend_clr = 1;
        else if (acc_r == H - 1 && acc_c == W - 1) pend_done = 1;
        if (acc_c == W - 1) begin acc_c = 0; acc_r++; end
        else acc_c++;
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_pix_ready"}, pix_ready, 0);
    chk({tag, "_pe_rst"}, pe_rst, 0);
    chk({tag, "_pe_en"}, pe_en, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_top"}, rd_top, 0);
    chk({tag, "_win_col"}, win_col, 0);
    chk({tag, "_win_col_sel"}, win_col_sel, 0);
    chk({tag, "_buf_wr_sel"}, buf_wr_sel, 1);
  endtask

  task automatic run_frame(input bit s, input int pct, input bit disturb);
    int d0;
    bit ok;
    push_model(s);
    @(posedge clk); #1;
    start = 1'b1; stride = s;
    @(posedge clk); #1;
    start = 1'b0;
    d0 = done_cnt; ok = 0;
    for (int k = 0; k < 3000; k++) begin
      if (done_cnt != d0) begin ok = 1; break; end
      pix_valid = ($urandom_range(99) < pct);
      if (disturb) begin start = 1'($urandom_range(1)); stride = 1'($urandom_range(1)); end
      @(posedge clk); #1;
    end
    start = 1'b0; pix_valid = 1'b0;
    chk("frame_completed", ok, 1);
    chk("window_count", wins, model_count(s));
    chk("queue_drained", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("idle_after_frame", busy, 0);
  endtask

  task automatic reset_mid_frame();
    bit ok;
    push_model(1'b0);
    @(posedge clk); #1;
    start = 1'b1; stride = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; pix_valid = 1'b1;
    ok = 0;
    for (int k = 0; k < 2000; k++) begin
      if (wins == 2 && pe_en) begin ok = 1; break; end
      @(posedge clk); #1;
    end
    chk("reached_third_mac", ok, 1);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    pix_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    run_frame(1'b0, 100, 1'b0);
    run_frame(1'b1, 100, 1'b0);
    run_frame(1'b0, 50, 1'b0);
    reset_mid_frame();
    run_frame(1'b0, 100, 1'b0);
    run_frame(1'b0, 70, 1'b1);
    run_frame(1'b1, 60, 1'b1);
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
